// File: rtl/vga_pkg.sv
// Shared raster timing definitions: SVGA 800x600@60 Hz constants, derived totals,
// counter width and a small window-decode helper used by the timing generator,
// overlay, detector and bench.
package vga_pkg;

    // Counter width shared by every stage that consumes hcount/vcount.
    localparam int unsigned CountWidth = 12;
    localparam int unsigned MaxTotal   = 1 << CountWidth;

    typedef logic [CountWidth-1:0] count_t;

    // SVGA 800x600@60 Hz, 40 MHz pixel clock.
    localparam int unsigned SvgaHActive = 800;
    localparam int unsigned SvgaHFp     = 40;
    localparam int unsigned SvgaHSync   = 128;
    localparam int unsigned SvgaHBp     = 88;
    localparam int unsigned SvgaVActive = 600;
    localparam int unsigned SvgaVFp     = 1;
    localparam int unsigned SvgaVSync   = 4;
    localparam int unsigned SvgaVBp     = 23;
    localparam logic        SvgaHPol    = 1'b1;
    localparam logic        SvgaVPol    = 1'b1;

    localparam int unsigned SvgaHTotal = SvgaHActive + SvgaHFp + SvgaHSync + SvgaHBp;
    localparam int unsigned SvgaVTotal = SvgaVActive + SvgaVFp + SvgaVSync + SvgaVBp;

    // True when lo <= v < lo + len.
    function automatic logic in_window(count_t v, int unsigned lo, int unsigned len);
        return (32'(v) >= lo) && (32'(v) < lo + len);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator. Counters advance on enabled pixel
// clocks; sync/blank are decoded from the next-state counter values so that all
// outputs are registers describing the same pixel in the same cycle.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = SvgaHActive,
    parameter int unsigned H_FP     = SvgaHFp,
    parameter int unsigned H_SYNC   = SvgaHSync,
    parameter int unsigned H_BP     = SvgaHBp,
    parameter int unsigned V_ACTIVE = SvgaVActive,
    parameter int unsigned V_FP     = SvgaVFp,
    parameter int unsigned V_SYNC   = SvgaVSync,
    parameter int unsigned V_BP     = SvgaVBp,
    parameter logic        H_POL    = SvgaHPol,
    parameter logic        V_POL    = SvgaVPol
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        en,
    output logic [11:0] hcount_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic [11:0] vcount_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic        line_start,
    output logic        frame_start
);

    localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Totals must fit the 12-bit counters.
    if (HTotal > MaxTotal || VTotal > MaxTotal || HTotal == 0 || VTotal == 0) begin : g_bad_params
        $error("vga_timing_gen: H_TOTAL=%0d / V_TOTAL=%0d out of range 1..%0d",
               HTotal, VTotal, MaxTotal);
    end

    localparam count_t HLast = count_t'(HTotal - 1);
    localparam count_t VLast = count_t'(VTotal - 1);

    count_t hc_q, hc_d;
    count_t vc_q, vc_d;
    logic   hsync_q, hsync_d;
    logic   hblnk_q, hblnk_d;
    logic   vsync_q, vsync_d;
    logic   vblnk_q, vblnk_d;
    logic   line_q, line_d;
    logic   frame_q, frame_d;

    // Next raster position and wrap strobes; everything holds while en is low.
    always_comb begin
        hc_d    = hc_q;
        vc_d    = vc_q;
        line_d  = 1'b0;
        frame_d = 1'b0;
        if (en) begin
            if (hc_q == HLast) begin
                hc_d   = '0;
                line_d = 1'b1;
                if (vc_q == VLast) begin
                    vc_d    = '0;
                    frame_d = 1'b1;
                end else begin
                    vc_d = vc_q + count_t'(1);
                end
            end else begin
                hc_d = hc_q + count_t'(1);
            end
        end
    end

    // Sync/blank decode from next-state counters; vc only changes at hc = 0,
    // so vertical sync/blank switch on whole-line boundaries.
    always_comb begin
        hblnk_d = (32'(hc_d) >= H_ACTIVE);
        vblnk_d = (32'(vc_d) >= V_ACTIVE);
        hsync_d = in_window(hc_d, H_ACTIVE + H_FP, H_SYNC) ? H_POL : ~H_POL;
        vsync_d = in_window(vc_d, V_ACTIVE + V_FP, V_SYNC) ? V_POL : ~V_POL;
    end

    // Timing bundle registers with asynchronous reset to the idle raster.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            hc_q    <= '0;
            vc_q    <= '0;
            hsync_q <= ~H_POL;
            hblnk_q <= 1'b0;
            vsync_q <= ~V_POL;
            vblnk_q <= 1'b0;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            hsync_q <= hsync_d;
            hblnk_q <= hblnk_d;
            vsync_q <= vsync_d;
            vblnk_q <= vblnk_d;
            line_q  <= line_d;
            frame_q <= frame_d;
        end
    end

    assign hcount_out  = hc_q;
    assign vcount_out  = vc_q;
    assign hsync_out   = hsync_q;
    assign hblnk_out   = hblnk_q;
    assign vsync_out   = vsync_q;
    assign vblnk_out   = vblnk_q;
    assign line_start  = line_q;
    assign frame_start = frame_q;

endmodule
